// File: rtl/countdown_pkg.sv
`default_nettype none
// countdown_pkg: shared state encoding, default seconds width and a saturating subtract
// for the countdown timer.
package countdown_pkg;

   localparam int TIME_W_DEFAULT = 11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      RUNNING = 3'd2,
      EXPIRED = 3'd3,
      DEFUSED = 3'd4
   } state_t;

   // a - b clamped at zero
   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? (a - b) : 32'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// tick_divider: counts 0..CLK_HZ-1 while enabled and flags the wrap cycle;
// clear forces the count back to zero, and the count holds while disabled.
module tick_divider #(
   parameter int CLK_HZ = 27_000_000
) (
   input  logic clock,
   input  logic reset_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

   logic [CNT_W-1:0] count;

   assign tick = enable && !clear && (count == LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// countdown_timer: loads a seconds total, counts it down at 1 Hz and flags expiry or defuse.
// Defining COUNTDOWN_PENALTY_EN builds the per-strike time penalty.
module countdown_timer #(
   parameter int CLK_HZ  = 27_000_000,
   parameter int TIME_W  = countdown_pkg::TIME_W_DEFAULT,
   parameter int PENALTY = 15
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [TIME_W-1:0] load_time,
   input  logic              load_valid,
   output logic              load_ack,
   input  logic              start,
   input  logic              defused,
   input  logic              strike,
   output logic [TIME_W-1:0] time_left,
   output logic [5:0]        minutes,
   output logic [5:0]        seconds,
   output logic              sec_tick,
   output logic              running,
   output logic              expired,
   output logic              done_ok
);

   import countdown_pkg::*;

   state_t            state, state_n;
   logic [TIME_W-1:0] time_n;
   logic              ack_n;
   logic              tick_n;
   logic              div_tick;
   logic              presc_clear;
   logic [31:0]       pen;
   logic [31:0]       dec;

   tick_divider #(
      .CLK_HZ (CLK_HZ)
   ) u_tick_divider (
      .clock   (clock),
      .reset_n (reset_n),
      .enable  (state == RUNNING),
      .clear   (presc_clear),
      .tick    (div_tick)
   );

`ifdef COUNTDOWN_PENALTY_EN
   assign pen = strike ? 32'(PENALTY) : 32'd0;
`else
   logic [32:0] unused_cfg;
   assign unused_cfg = {strike, 32'(PENALTY)};
   assign pen        = 32'd0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         time_left <= '0;
         load_ack  <= 1'b0;
         sec_tick  <= 1'b0;
      end else begin
         state     <= state_n;
         time_left <= time_n;
         load_ack  <= ack_n;
         sec_tick  <= tick_n;
      end
   end

   always_comb begin
      state_n     = state;
      time_n      = time_left;
      ack_n       = 1'b0;
      tick_n      = 1'b0;
      presc_clear = 1'b0;
      dec         = 32'd0;
      case (state)
         IDLE: begin
            if (load_valid) begin
               time_n  = load_time;
               ack_n   = 1'b1;
               state_n = ARMED;
            end
         end
         ARMED: begin
            if (start) begin
               presc_clear = 1'b1;
               state_n     = (time_left == '0) ? EXPIRED : RUNNING;
            end else if (load_valid) begin
               time_n = load_time;
               ack_n  = 1'b1;
            end
         end
         RUNNING: begin
            // Defuse wins over a coincident tick or strike: time freezes as-is
            if (defused) begin
               state_n = DEFUSED;
            end else begin
               dec = 32'(div_tick) + pen;
               if (dec != 32'd0) begin
                  time_n = TIME_W'(sat_sub(32'(time_left), dec));
                  tick_n = div_tick;
                  if (time_n == '0) begin
                     state_n = EXPIRED;
                  end
               end
            end
         end
         default: begin
         end
      endcase
   end

   assign minutes = 6'(time_left / TIME_W'(60));
   assign seconds = 6'(time_left % TIME_W'(60));
   assign running = (state == RUNNING);
   assign expired = (state == EXPIRED);
   assign done_ok = (state == DEFUSED);

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// tb_countdown_timer: directed and randomized checks of countdown_timer (CLK_HZ=4)
// against an arithmetic model of elapsed seconds.
module tb_countdown_timer;

   localparam int HZ = 4;

   logic        clock;
   logic        reset_n;
   logic [10:0] load_time;
   logic        load_valid;
   logic        load_ack;
   logic        start;
   logic        defused;
   logic        strike;
   logic [10:0] time_left;
   logic [5:0]  minutes;
   logic [5:0]  seconds;
   logic        sec_tick;
   logic        running;
   logic        expired;
   logic        done_ok;

   int checks = 0;
   int errors = 0;

   countdown_timer #(
      .CLK_HZ  (HZ),
      .TIME_W  (11),
      .PENALTY (15)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_time  (load_time),
      .load_valid (load_valid),
      .load_ack   (load_ack),
      .start      (start),
      .defused    (defused),
      .strike     (strike),
      .time_left  (time_left),
      .minutes    (minutes),
      .seconds    (seconds),
      .sec_tick   (sec_tick),
      .running    (running),
      .expired    (expired),
      .done_ok    (done_ok)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
   endtask

   task automatic load(input int t);
      load_time  = 11'(t);
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      chk("load_ack", load_ack, 1);
      chk("load_time_left", time_left, t);
   endtask

   // Starts from ARMED with t0 loaded and checks every cycle against elapsed-time arithmetic.
   // dn: edge number from which defused is held high (0 = never); poke: edge with load/start noise.
   task automatic run_check(input int t0, input int ncyc, input int dn, input int poke);
      int  eff, ticks, tl;
      bit  dflag, done_e, exp_e, tick_e;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start_running", running, 1);
      chk("start_time", time_left, t0);
      for (int n = 1; n <= ncyc; n++) begin
         defused    = (dn > 0) && (n >= dn);
         load_valid = (n == poke);
         start      = (n == poke);
         load_time  = 11'($urandom_range(0, 2047));
         step();
         dflag  = (dn > 0) && (n >= dn);
         eff    = dflag ? dn - 1 : n;
         ticks  = (eff / HZ < t0) ? eff / HZ : t0;
         tl     = t0 - ticks;
         done_e = dflag && ((dn - 1) / HZ < t0);
         exp_e  = (tl == 0);
         tick_e = !dflag && (n % HZ == 0) && (n / HZ <= t0);
         chk($sformatf("time_left@%0d", n), time_left, tl);
         chk($sformatf("sec_tick@%0d", n), sec_tick, tick_e);
         chk($sformatf("expired@%0d", n), expired, exp_e);
         chk($sformatf("done_ok@%0d", n), done_ok, done_e);
         chk($sformatf("running@%0d", n), running, !done_e && !exp_e);
         chk($sformatf("no_ack@%0d", n), load_ack, 0);
         chk($sformatf("minutes@%0d", n), minutes, tl / 60);
         chk($sformatf("seconds@%0d", n), seconds, tl % 60);
      end
      defused    = 1'b0;
      load_valid = 1'b0;
      start      = 1'b0;
   endtask

   initial begin
      int t0, ncyc, dn, poke;
      reset_n    = 1'b0;
      load_time  = '0;
      load_valid = 1'b0;
      start      = 1'b0;
      defused    = 1'b0;
      strike     = 1'b0;
      step();
      step();
      chk("rst_time_left", time_left, 0);
      chk("rst_load_ack", load_ack, 0);
      chk("rst_sec_tick", sec_tick, 0);
      chk("rst_running", running, 0);
      chk("rst_expired", expired, 0);
      chk("rst_done_ok", done_ok, 0);
      chk("rst_minutes", minutes, 0);
      chk("rst_seconds", seconds, 0);
      reset_n = 1'b1;

      // Basic load and full countdown to expiry
      load(5);
      chk("armed_running", running, 0);
      step();
      chk("ack_one_cycle", load_ack, 0);
      run_check(5, 26, 0, 0);

      // Re-capture in ARMED, then start at zero expires at once
      do_reset();
      load(7);
      load(9);
      load(0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("zero_start_expired", expired, 1);
      chk("zero_start_running", running, 0);
      chk("zero_start_tick", sec_tick, 0);
      load_valid = 1'b1;
      load_time  = 11'd33;
      step();
      load_valid = 1'b0;
      chk("expired_no_ack", load_ack, 0);
      chk("expired_hold_time", time_left, 0);
      chk("expired_hold", expired, 1);

      // min/sec split across a minute boundary, with load/start noise while running
      do_reset();
      load(125);
      chk("split_min", minutes, 2);
      chk("split_sec", seconds, 5);
      run_check(125, 24, 0, 2);
      chk("split_min_after6", minutes, 1);
      chk("split_sec_after6", seconds, 59);

      // Defuse on the same edge as the final tick
      do_reset();
      load(3);
      run_check(3, 16, 12, 0);
      chk("defuse_final_done", done_ok, 1);
      chk("defuse_final_time", time_left, 1);

      // Asynchronous reset mid-run, off the clock edge, right after a tick
      do_reset();
      load(30);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      chk("pre_reset_time", time_left, 28);
      chk("pre_reset_tick", sec_tick, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_time", time_left, 0);
      chk("async_rst_tick", sec_tick, 0);
      chk("async_rst_running", running, 0);
      step();
      reset_n = 1'b1;
      load(4);

      // Strike handling
      do_reset();
      load(20);
      strike = 1'b1;
      step();
      strike = 1'b0;
      chk("strike_armed_ignored", time_left, 20);
      start = 1'b1;
      step();
      start  = 1'b0;
      strike = 1'b1;
      step();
      strike = 1'b0;
`ifdef COUNTDOWN_PENALTY_EN
      chk("strike_penalty", time_left, 5);
`else
      chk("strike_ignored", time_left, 20);
`endif
      chk("strike_no_tick", sec_tick, 0);

      do_reset();
      load(10);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      strike = 1'b1;
      step();
      strike = 1'b0;
      chk("strike_tick_pulse", sec_tick, 1);
`ifdef COUNTDOWN_PENALTY_EN
      chk("strike_tick_time", time_left, 0);
      chk("strike_tick_expired", expired, 1);
`else
      chk("strike_tick_time", time_left, 9);
      chk("strike_tick_expired", expired, 0);
`endif

      // Randomized runs
      for (int r = 0; r < 6; r++) begin
         t0   = $urandom_range(1, 30);
         ncyc = t0 * HZ + 6;
         dn   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, ncyc) : 0;
         poke = $urandom_range(1, ncyc);
         do_reset();
         load(t0);
         run_check(t0, ncyc, dn, poke);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
